// File: rtl/board_input_conditioner.sv
// board_input_conditioner: synchronizes and debounces KEY[3:1] and SW[17:0] into CLOCK_50,
// producing clean levels plus one-cycle press/release/change pulses.   Rev 1.0
`default_nettype none

module board_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2,
  parameter int KEY_WIDTH       = 3,
  parameter int SW_WIDTH        = 18
) (
  input  logic                 CLOCK_50,
  input  logic                 KEY0,
  input  logic [KEY_WIDTH-1:0] key_raw,
  input  logic [SW_WIDTH-1:0]  sw_raw,
  output logic [KEY_WIDTH-1:0] key_level,
  output logic [KEY_WIDTH-1:0] key_press,
  output logic [KEY_WIDTH-1:0] key_release,
  output logic [SW_WIDTH-1:0]  sw_stable,
  output logic                 sw_changed
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [0:0] {
    RELEASED = 1'b0,
    PRESSED  = 1'b1
  } key_state_t;

  logic [KEY_WIDTH-1:0] key_sync [SYNC_STAGES];
  logic [SW_WIDTH-1:0]  sw_sync  [SYNC_STAGES];
  logic [KEY_WIDTH-1:0] ks;
  logic [SW_WIDTH-1:0]  ss;

  // Keys reset to the released (high) level so a held key is re-debounced after reset.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        key_sync[i] <= '1;
        sw_sync[i]  <= '0;
      end
    end else begin
      key_sync[0] <= key_raw;
      sw_sync[0]  <= sw_raw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        key_sync[i] <= key_sync[i-1];
        sw_sync[i]  <= sw_sync[i-1];
      end
    end
  end

  assign ks = ~key_sync[SYNC_STAGES-1];
  assign ss = sw_sync[SYNC_STAGES-1];

  generate
    for (genvar g = 0; g < KEY_WIDTH; g++) begin : g_key
      key_state_t       state;
      logic [CNT_W-1:0] cnt;
      logic             press;
      logic             rel;

      always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
          state <= RELEASED;
          cnt   <= '0;
          press <= 1'b0;
          rel   <= 1'b0;
        end else begin
          press <= 1'b0;
          rel   <= 1'b0;
          case (state)
            RELEASED: begin
              if (!ks[g]) begin
                cnt <= '0;
              end else if (cnt == CNT_LAST) begin
                state <= PRESSED;
                cnt   <= '0;
                press <= 1'b1;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
            PRESSED: begin
              if (ks[g]) begin
                cnt <= '0;
              end else if (cnt == CNT_LAST) begin
                state <= RELEASED;
                cnt   <= '0;
                rel   <= 1'b1;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
            default: begin
              state <= RELEASED;
              cnt   <= '0;
            end
          endcase
        end
      end

      assign key_level[g]   = (state == PRESSED);
      assign key_press[g]   = press;
      assign key_release[g] = rel;
    end
  endgenerate

  logic [SW_WIDTH-1:0] sw_cand;
  logic [CNT_W-1:0]    sw_cnt;

  // The whole bank shares one qualification window; any bit moving restarts it.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      sw_cand    <= '0;
      sw_cnt     <= '0;
      sw_stable  <= '0;
      sw_changed <= 1'b0;
    end else begin
      sw_changed <= 1'b0;
      if (ss != sw_cand) begin
        sw_cand <= ss;
        sw_cnt  <= '0;
      end else if (sw_cand != sw_stable) begin
        if (sw_cnt == CNT_LAST) begin
          sw_stable  <= sw_cand;
          sw_cnt     <= '0;
          sw_changed <= 1'b1;
        end else begin
          sw_cnt <= sw_cnt + CNT_W'(1);
        end
      end else begin
        sw_cnt <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_board_input_conditioner.sv
// tb_board_input_conditioner: directed vector table plus hand-written corner sequences
// for board_input_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.   Rev 1.0
`default_nettype none

module tb_board_input_conditioner;

  logic        clk = 1'b0;
  logic        key0;
  logic [2:0]  key_raw;
  logic [17:0] sw_raw;
  logic [2:0]  key_level;
  logic [2:0]  key_press;
  logic [2:0]  key_release;
  logic [17:0] sw_stable;
  logic        sw_changed;

  always #5 clk = ~clk;

  board_input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .SYNC_STAGES    (2),
    .KEY_WIDTH      (3),
    .SW_WIDTH       (18)
  ) dut (
    .CLOCK_50   (clk),
    .KEY0       (key0),
    .key_raw    (key_raw),
    .sw_raw     (sw_raw),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .sw_stable  (sw_stable),
    .sw_changed (sw_changed)
  );

  typedef struct {
    logic        rst_n;
    logic [2:0]  key;
    logic [17:0] sw;
    logic [2:0]  lvl;
    logic [2:0]  prs;
    logic [2:0]  rel;
    logic [17:0] stb;
    logic        chg;
  } vec_t;

  vec_t vecs[$];
  int   passed = 0;
  int   total  = 0;

  task automatic push(input int n, input logic r, input logic [2:0] k, input logic [17:0] s,
                      input logic [2:0] l, input logic [2:0] p, input logic [2:0] rl,
                      input logic [17:0] st, input logic c);
    vec_t v;
    v.rst_n = r;  v.key = k;  v.sw  = s;
    v.lvl   = l;  v.prs = p;  v.rel = rl;
    v.stb   = st; v.chg = c;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [2:0] l, input logic [2:0] p,
                     input logic [2:0] rl, input logic [17:0] st, input logic c);
    total++;
    if (key_level !== l || key_press !== p || key_release !== rl ||
        sw_stable !== st || sw_changed !== c)
      $display("FAIL %s @%0t: got lvl=%b prs=%b rel=%b stb=%h chg=%b, expected lvl=%b prs=%b rel=%b stb=%h chg=%b",
               name, $time, key_level, key_press, key_release, sw_stable, sw_changed,
               l, p, rl, st, c);
    else
      passed++;
  endtask

  task automatic cyc(input string name, input logic [2:0] l, input logic [2:0] p,
                     input logic [2:0] rl, input logic [17:0] st, input logic c);
    @(posedge clk);
    #1;
    chk(name, l, p, rl, st, c);
  endtask

  initial begin
    key0    = 1'b0;
    key_raw = 3'b000;
    sw_raw  = 18'h3FFFF;

    // Reset with all keys held, then startup qualification of keys (6) and switches (7,
    // the candidate register adds one cycle), release of all keys, clean press/release of key 0.
    push(3,  1'b0, 3'b000, 18'h3FFFF, 3'b000, 3'b000, 3'b000, 18'h00000, 1'b0);
    push(5,  1'b1, 3'b000, 18'h3FFFF, 3'b000, 3'b000, 3'b000, 18'h00000, 1'b0);
    push(1,  1'b1, 3'b000, 18'h3FFFF, 3'b111, 3'b111, 3'b000, 18'h00000, 1'b0);
    push(1,  1'b1, 3'b000, 18'h3FFFF, 3'b111, 3'b000, 3'b000, 18'h3FFFF, 1'b1);
    push(1,  1'b1, 3'b000, 18'h3FFFF, 3'b111, 3'b000, 3'b000, 18'h3FFFF, 1'b0);
    push(5,  1'b1, 3'b111, 18'h3FFFF, 3'b111, 3'b000, 3'b000, 18'h3FFFF, 1'b0);
    push(1,  1'b1, 3'b111, 18'h3FFFF, 3'b000, 3'b000, 3'b111, 18'h3FFFF, 1'b0);
    push(1,  1'b1, 3'b111, 18'h3FFFF, 3'b000, 3'b000, 3'b000, 18'h3FFFF, 1'b0);
    push(5,  1'b1, 3'b110, 18'h3FFFF, 3'b000, 3'b000, 3'b000, 18'h3FFFF, 1'b0);
    push(1,  1'b1, 3'b110, 18'h3FFFF, 3'b001, 3'b001, 3'b000, 18'h3FFFF, 1'b0);
    push(14, 1'b1, 3'b110, 18'h3FFFF, 3'b001, 3'b000, 3'b000, 18'h3FFFF, 1'b0);
    push(5,  1'b1, 3'b111, 18'h3FFFF, 3'b001, 3'b000, 3'b000, 18'h3FFFF, 1'b0);
    push(1,  1'b1, 3'b111, 18'h3FFFF, 3'b000, 3'b000, 3'b001, 18'h3FFFF, 1'b0);
    push(2,  1'b1, 3'b111, 18'h3FFFF, 3'b000, 3'b000, 3'b000, 18'h3FFFF, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      key0    = vecs[i].rst_n;
      key_raw = vecs[i].key;
      sw_raw  = vecs[i].sw;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].prs, vecs[i].rel, vecs[i].stb, vecs[i].chg);
    end

    // Bounce on key 1: 2-cycle segments never reach the 4-sample window.
    for (int i = 0; i < 12; i++) begin
      key_raw = {1'b1, ((i / 2) % 2 == 1), 1'b1};
      cyc("bounce", 3'b000, 3'b000, 3'b000, 18'h3FFFF, 1'b0);
    end
    key_raw = 3'b101;
    for (int k = 1; k <= 7; k++)
      cyc("bounce_press", (k >= 6) ? 3'b010 : 3'b000, (k == 6) ? 3'b010 : 3'b000,
          3'b000, 18'h3FFFF, 1'b0);
    key_raw = 3'b111;
    for (int k = 1; k <= 7; k++)
      cyc("bounce_release", (k < 6) ? 3'b010 : 3'b000, 3'b000,
          (k == 6) ? 3'b010 : 3'b000, 18'h3FFFF, 1'b0);

    // Three-cycle glitch on key 2 is one sample short of qualifying.
    key_raw = 3'b011;
    for (int k = 0; k < 3; k++) cyc("glitch_low", 3'b000, 3'b000, 3'b000, 18'h3FFFF, 1'b0);
    key_raw = 3'b111;
    for (int k = 0; k < 8; k++) cyc("glitch_after", 3'b000, 3'b000, 3'b000, 18'h3FFFF, 1'b0);

    // Switch bank updates, then a 2-cycle glitch on sw[3] that returns before qualifying.
    sw_raw = 18'h00004;
    for (int k = 1; k <= 8; k++)
      cyc("sw_to_4", 3'b000, 3'b000, 3'b000, (k >= 7) ? 18'h00004 : 18'h3FFFF, (k == 7));
    sw_raw = 18'h00005;
    for (int k = 1; k <= 8; k++)
      cyc("sw_to_5", 3'b000, 3'b000, 3'b000, (k >= 7) ? 18'h00005 : 18'h00004, (k == 7));
    sw_raw = 18'h0000D;
    for (int k = 0; k < 2; k++) cyc("sw_glitch", 3'b000, 3'b000, 3'b000, 18'h00005, 1'b0);
    sw_raw = 18'h00005;
    for (int k = 0; k < 8; k++) cyc("sw_glitch_after", 3'b000, 3'b000, 3'b000, 18'h00005, 1'b0);

    // Reset while key 0 is held: clears asynchronously, then a fresh press after deassertion.
    key_raw = 3'b110;
    for (int k = 1; k <= 7; k++)
      cyc("pre_reset_press", (k >= 6) ? 3'b001 : 3'b000, (k == 6) ? 3'b001 : 3'b000,
          3'b000, 18'h00005, 1'b0);
    key0 = 1'b0;
    #1;
    chk("async_reset", 3'b000, 3'b000, 3'b000, 18'h00000, 1'b0);
    for (int k = 0; k < 2; k++) cyc("in_reset", 3'b000, 3'b000, 3'b000, 18'h00000, 1'b0);
    key0 = 1'b1;
    for (int k = 1; k <= 8; k++)
      cyc("post_reset", (k >= 6) ? 3'b001 : 3'b000, (k == 6) ? 3'b001 : 3'b000, 3'b000,
          (k >= 7) ? 18'h00005 : 18'h00000, (k == 7));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
